// File: rtl/framebuffer_writer_if.sv
`default_nettype none
// ============================================================================
// framebuffer_writer_pkg / framebuffer_writer_if
// Shared colour type and the valid/ready memory-write port of the framebuffer writer.
// Revision: 1.0
// ============================================================================
package framebuffer_writer_pkg;
    typedef struct packed {
        logic signed [31:0] r;
        logic signed [31:0] g;
        logic signed [31:0] b;
        logic signed [31:0] a;
    } Vector4_t;
endpackage

interface framebuffer_writer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_data;
    logic              i_mem_ready;

    modport master (
        output o_mem_we,
        output o_mem_addr,
        output o_mem_data,
        input  i_mem_ready
    );

    modport slave (
        input  o_mem_we,
        input  o_mem_addr,
        input  o_mem_data,
        output i_mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/framebuffer_writer.sv
`default_nettype none
// ============================================================================
// framebuffer_writer
// Clips rasteriser pixels, packs RGBA8888, queues them and owns the clear sequencer.
// Revision: 1.0
// ============================================================================
module framebuffer_writer
    import framebuffer_writer_pkg::*;
#(
    parameter int unsigned WIDTH      = 640,
    parameter int unsigned HEIGHT     = 480,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  wire logic               i_clk,
    input  wire logic               i_reset_n,
    input  wire logic               i_write,
    input  wire Vector4_t           i_colour,
    input  wire logic signed [31:0] i_x,
    input  wire logic signed [31:0] i_y,
    output logic                    o_ready,
    input  wire logic               i_clear,
    input  wire Vector4_t           i_clear_colour,
    framebuffer_writer_if.master    mem,
    output logic                    o_busy,
    output logic [15:0]             o_clipped,
    output logic [15:0]             o_dropped
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam int unsigned        PTR_W       = $clog2(FIFO_DEPTH);
    localparam int unsigned        CNT_W       = PTR_W + 1;
    localparam logic [ADDR_W-1:0]  C_BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0]  C_LAST      = ADDR_W'(BASE_ADDR + WIDTH * HEIGHT - 1);
    localparam logic signed [31:0] C_WIDTH_S   = 32'(WIDTH);
    localparam logic signed [31:0] C_HEIGHT_S  = 32'(HEIGHT);
    localparam logic [CNT_W:0]     C_READY_MAX = (CNT_W+1)'(FIFO_DEPTH - 2);

    function automatic logic [7:0] to_u8(input logic signed [31:0] c);
        if (c < 32'sd0)
            return 8'd0;
        else if (c >= 32'sh0001_0000)
            return 8'hFF;
        else
            return c[15:8];
    endfunction

    function automatic logic [31:0] pack_colour(input Vector4_t v);
        return {to_u8(v.r), to_u8(v.g), to_u8(v.b), to_u8(v.a)};
    endfunction

    state_t            state_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic [31:0]       clr_data_q;

    logic              stage_valid_q;
    logic [ADDR_W-1:0] stage_addr_q;
    logic [31:0]       stage_data_q;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [31:0]       fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  fifo_count_q;
    logic [CNT_W-1:0]  fifo_count_d;

    logic [15:0]       clipped_q;
    logic [15:0]       clipped_d;
    logic [15:0]       dropped_q;
    logic [15:0]       dropped_d;

    logic              w_fifo_empty;
    logic              w_on_screen;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_pix_addr;

    assign w_fifo_empty = (fifo_count_q == '0);
    assign w_on_screen  = (i_x >= 32'sd0) && (i_x < C_WIDTH_S) &&
                          (i_y >= 32'sd0) && (i_y < C_HEIGHT_S);
    assign w_pix_addr   = C_BASE + ADDR_W'(i_y) * ADDR_W'(WIDTH) + ADDR_W'(i_x);
    assign w_accept     = i_write && o_ready;
    assign w_push       = stage_valid_q;
    // The FIFO is always empty in CLEAR, so the head never competes with the sequencer.
    assign w_pop        = !w_fifo_empty && mem.i_mem_ready;
    assign fifo_count_d = fifo_count_q + CNT_W'(w_push) - CNT_W'(w_pop);

    assign o_ready   = (state_q == IDLE) &&
                       (({1'b0, fifo_count_q} + {{CNT_W{1'b0}}, stage_valid_q}) <= C_READY_MAX);
    assign o_busy    = stage_valid_q || !w_fifo_empty || (state_q != IDLE);
    assign o_clipped = clipped_q;
    assign o_dropped = dropped_q;

    always_comb begin
        clipped_d = clipped_q;
        dropped_d = dropped_q;
        if (w_accept && !w_on_screen && (clipped_q != 16'hFFFF))
            clipped_d = clipped_q + 16'd1;
        if (i_write && !o_ready && (dropped_q != 16'hFFFF))
            dropped_d = dropped_q + 16'd1;
    end

    always_comb begin
        mem.o_mem_we   = 1'b0;
        mem.o_mem_addr = '0;
        mem.o_mem_data = '0;
        if (state_q == CLEAR) begin
            mem.o_mem_we   = 1'b1;
            mem.o_mem_addr = clr_addr_q;
            mem.o_mem_data = clr_data_q;
        end else if (!w_fifo_empty) begin
            mem.o_mem_we   = 1'b1;
            mem.o_mem_addr = fifo_addr_q[rd_ptr_q];
            mem.o_mem_data = fifo_data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stage_valid_q <= 1'b0;
            stage_addr_q  <= '0;
            stage_data_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_count_q  <= '0;
            clipped_q     <= '0;
            dropped_q     <= '0;
        end else begin
            stage_valid_q <= w_accept && w_on_screen;
            if (w_accept && w_on_screen) begin
                stage_addr_q <= w_pix_addr;
                stage_data_q <= pack_colour(i_colour);
            end
            if (w_push)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fifo_count_q <= fifo_count_d;
            clipped_q    <= clipped_d;
            dropped_q    <= dropped_d;
        end
    end

    // Storage needs no reset: entries are only read while the count says they are valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            fifo_addr_q[wr_ptr_q] <= stage_addr_q;
            fifo_data_q[wr_ptr_q] <= stage_data_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            clr_addr_q <= '0;
            clr_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_clear) begin
                        clr_data_q <= pack_colour(i_clear_colour);
                        state_q    <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (!stage_valid_q && w_fifo_empty) begin
                        clr_addr_q <= C_BASE;
                        state_q    <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (mem.i_mem_ready) begin
                        if (clr_addr_q == C_LAST)
                            state_q <= IDLE;
                        else
                            clr_addr_q <= clr_addr_q + ADDR_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_writer.sv
`default_nettype none
// ============================================================================
// tb_framebuffer_writer
// Randomised scoreboard bench for framebuffer_writer against a behavioural pixel model.
// Revision: 1.0
// ============================================================================
module tb_framebuffer_writer;
    import framebuffer_writer_pkg::*;

    localparam int W    = 640;
    localparam int H    = 4;
    localparam int BASE = 32'h1000;
    localparam int AW   = 32;
    localparam int D    = 8;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          is_clear;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               wr = 1'b0;
    logic               clr = 1'b0;
    Vector4_t           col = '0;
    Vector4_t           ccol = '0;
    logic signed [31:0] x = '0;
    logic signed [31:0] y = '0;
    logic               rdy;
    logic               busy;
    logic [15:0]        clipped;
    logic [15:0]        dropped;

    framebuffer_writer_if #(.ADDR_W(AW)) mif ();

    framebuffer_writer #(
        .WIDTH(W), .HEIGHT(H), .BASE_ADDR(BASE), .ADDR_W(AW), .FIFO_DEPTH(D)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_write(wr), .i_colour(col),
        .i_x(x), .i_y(y), .o_ready(rdy), .i_clear(clr), .i_clear_colour(ccol),
        .mem(mif), .o_busy(busy), .o_clipped(clipped), .o_dropped(dropped)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    exp_t   q[$];
    int     ready_mode = 1;
    int     model_clipped = 0;
    int     model_dropped = 0;
    int     accepted = 0;
    bit     clear_active = 0;
    longint last_acc_cyc = 0;
    longint last_xfer_cyc = 0;
    longint last_clear_pop_cyc = 0;
    bit          stall_valid = 0;
    logic [31:0] stall_addr, stall_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference rules written as plain arithmetic on integers.
    function automatic logic [7:0] u8(input int v);
        if (v < 0) return 8'd0;
        if (v >= 65536) return 8'd255;
        return 8'(v / 256);
    endfunction

    function automatic logic [31:0] pack_model(input Vector4_t c);
        return {u8(c.r), u8(c.g), u8(c.b), u8(c.a)};
    endfunction

    function automatic bit on_screen(input int px, input int py);
        return px >= 0 && px < W && py >= 0 && py < H;
    endfunction

    function automatic logic [31:0] addr_of(input int px, input int py);
        longint a;
        a = longint'(BASE) + longint'(py) * W + px;
        return a[31:0];
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic int rnd_comp();
        case ($urandom_range(0, 5))
            0:       return -int'($urandom_range(1, 70000));
            1:       return 32'h10000;
            2:       return 32'hFFFF;
            3:       return 0;
            4:       return int'($urandom_range(65536, 200000));
            default: return int'($urandom_range(0, 65535));
        endcase
    endfunction

    function automatic Vector4_t rnd_colour();
        Vector4_t c;
        c.r = rnd_comp(); c.g = rnd_comp(); c.b = rnd_comp(); c.a = rnd_comp();
        return c;
    endfunction

    initial begin
        mif.i_mem_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       mif.i_mem_ready = 1'b0;
                1:       mif.i_mem_ready = 1'b1;
                default: mif.i_mem_ready = ($urandom_range(0, 99) < 60);
            endcase
        end
    end

    // Monitor: pops the scoreboard on every transfer, checks hold-stability while stalled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_valid = 0;
            end else if (mif.o_mem_we) begin
                if (stall_valid) begin
                    check("stall_addr", mif.o_mem_addr, stall_addr);
                    check("stall_data", mif.o_mem_data, stall_data);
                end
                if (mif.i_mem_ready) begin
                    stall_valid = 0;
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write: addr=0x%0h data=0x%0h, required no write",
                                 mif.o_mem_addr, mif.o_mem_data);
                    end else begin
                        e = q.pop_front();
                        check(e.is_clear ? "clear_addr" : "pix_addr", mif.o_mem_addr, e.addr);
                        check(e.is_clear ? "clear_data" : "pix_data", mif.o_mem_data, e.data);
                        last_xfer_cyc = cyc;
                        if (e.is_clear) last_clear_pop_cyc = cyc;
                    end
                end else begin
                    stall_valid = 1;
                    stall_addr  = mif.o_mem_addr;
                    stall_data  = mif.o_mem_data;
                end
            end else if (stall_valid) begin
                check("we_held_while_stalled", mif.o_mem_we, 1);
                stall_valid = 0;
            end
        end
    end

    task automatic pixel_cycle(input bit w, input int px, input int py, input Vector4_t c);
        exp_t e;
        @(posedge clk); #1;
        wr = w; x = px; y = py; col = c; clr = 1'b0;
        if (!clear_active)
            check("ready_model", rdy, (q.size() <= D - 2));
        if (w) begin
            if (rdy) begin
                accepted++;
                last_acc_cyc = cyc;
                if (on_screen(px, py)) begin
                    e.addr = addr_of(px, py);
                    e.data = pack_model(c);
                    e.is_clear = 0;
                    q.push_back(e);
                end else begin
                    model_clipped = sat16(model_clipped + 1);
                end
            end else begin
                model_dropped = sat16(model_dropped + 1);
            end
        end
    endtask

    task automatic idle_cycle();
        pixel_cycle(0, 0, 0, '0);
    endtask

    task automatic issue_clear(input Vector4_t c);
        exp_t e;
        @(posedge clk); #1;
        wr = 1'b0; clr = 1'b1; ccol = c;
        for (int i = 0; i < W * H; i++) begin
            e.addr = 32'(BASE + i);
            e.data = pack_model(c);
            e.is_clear = 1;
            q.push_back(e);
        end
        clear_active = 1;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_idle: busy=1 after %0d cycles, required 0", budget);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached with %0d entries pending", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        Vector4_t c;
        int px, py;

        #1 rst_n = 1'b0;
        #1;
        check("reset_we", mif.o_mem_we, 0);
        check("reset_addr", mif.o_mem_addr, 0);
        check("reset_data", mif.o_mem_data, 0);
        check("reset_busy", busy, 0);
        check("reset_clipped", clipped, 0);
        check("reset_dropped", dropped, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", rdy, 1);

        // Single pixel with latency measurement.
        ready_mode = 1;
        c.r = 32'sh8000; c.g = 32'sh10000; c.b = -32'sd1; c.a = 32'sh4000;
        pixel_cycle(1, 3, 2, c);
        idle_cycle();
        wait_idle(50);
        check("single_latency", last_xfer_cyc - last_acc_cyc, 2);

        // Clipping boundaries.
        pixel_cycle(1, -1, 0, c);
        pixel_cycle(1, W, 0, c);
        pixel_cycle(1, 0, H, c);
        pixel_cycle(1, 0, -1, c);
        idle_cycle();
        @(negedge clk);
        check("clip_busy", busy, 0);
        check("clip_count", clipped, model_clipped);

        // Backpressure: FIFO fills, o_ready falls, writes drain in order.
        ready_mode = 0;
        accepted = 0;
        for (int i = 0; i < 12; i++)
            pixel_cycle(1, int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)),
                        rnd_colour());
        idle_cycle();
        check("bp_accepted", accepted, 7);
        check("bp_dropped", dropped, model_dropped);
        repeat (3) idle_cycle();
        ready_mode = 2;
        idle_cycle();
        wait_idle(300);

        // Clear with two queued pixels and pixels presented during flush/clear.
        ready_mode = 0;
        pixel_cycle(1, 10, 1, rnd_colour());
        pixel_cycle(1, 11, 1, rnd_colour());
        idle_cycle();
        c.r = 32'sh10000; c.g = 32'sh10000; c.b = 32'sh10000; c.a = 32'sh10000;
        issue_clear(c);
        pixel_cycle(1, 7, 3, rnd_colour());
        check("ready_in_flush", rdy, 0);
        repeat (3) idle_cycle();
        ready_mode = 2;
        repeat (20) idle_cycle();
        pixel_cycle(1, 1, 1, rnd_colour());
        check("ready_in_clear", rdy, 0);
        idle_cycle();
        wait_idle(20000);
        check("clear_to_idle_cycle", cyc, last_clear_pop_cyc + 1);
        check("ready_after_clear", rdy, 1);
        check("clear_queue_drained", q.size(), 0);
        check("clear_dropped", dropped, model_dropped);
        clear_active = 0;

        // Random traffic under random memory throttling.
        ready_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                px = int'($urandom);
                py = int'($urandom_range(0, H + 3)) - 2;
            end else begin
                px = int'($urandom_range(0, W + 5)) - 3;
                py = int'($urandom_range(0, H + 3)) - 2;
            end
            pixel_cycle($urandom_range(0, 99) < 85, px, py, rnd_colour());
        end
        idle_cycle();
        wait_idle(2000);
        check("rand_clipped", clipped, model_clipped);
        check("rand_dropped", dropped, model_dropped);
        check("rand_queue_drained", q.size(), 0);

        // Reset in the middle of a clear.
        ready_mode = 1;
        issue_clear(rnd_colour());
        repeat (40) idle_cycle();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midclear_reset_we", mif.o_mem_we, 0);
        check("midclear_reset_busy", busy, 0);
        check("midclear_reset_clipped", clipped, 0);
        check("midclear_reset_dropped", dropped, 0);
        q.delete();
        model_clipped = 0;
        model_dropped = 0;
        clear_active = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_abort", rdy, 1);
        check("busy_after_abort", busy, 0);
        pixel_cycle(1, W - 1, H - 1, rnd_colour());
        idle_cycle();
        wait_idle(50);
        check("post_abort_queue", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
